dna_reader: RTL and testbench

Parametrised device-DNA reader that drives the FPGA DNA_PORT primitive through a load/settle/shift sequence and returns the serial ID as a parallel word. Successor to the fixed single-pass capture: it adds configurable width, delays and number of read passes, cross-checks the passes, and compares the result against a masked expected ID. It also supports re-reads on request. It sits beside the system-control logic on `sys_clk` and feeds licence/board-identification logic.

---
 rtl/dna_reader_pkg.sv | 29 ++
 rtl/dna_reader_port_if.sv | 28 ++
 rtl/dna_reader.sv | 152 +++++++++++++++
 tb/tb_dna_reader.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/dna_reader_pkg.sv
// Shared definitions for the device-DNA reader: FSM encoding, chip defaults
// and a small sizing helper.
package dna_reader_pkg;

   // Reader sequence states, 3-bit encoding.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_WAIT   = 3'd1,
      ST_LOAD   = 3'd2,
      ST_SETTLE = 3'd3,
      ST_SHIFT  = 3'd4,
      ST_CHECK  = 3'd5,
      ST_DONE   = 3'd6
   } state_t;

   // ID length of the DNA_PORT on the supported chip family.
   localparam int DEF_DNA_WIDTH = 57;

   // Simulation ID reported by the primitive model unless overridden.
   localparam logic [56:0] DEF_SIM_DNA = 57'h1_2345_6789_ABCD_EF;

   // Largest of three values, used to size the shared cycle counter.
   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/dna_reader_port_if.sv
// Wrapper around the DNA_PORT primitive: READ, SHIFT and DOUT pass straight
// through and DIN is tied low. The only state here is the behavioural model
// of the primitive's own internal shift register.
module dna_reader_port_if #(
   parameter int                   DNA_WIDTH = 57,
   parameter logic [DNA_WIDTH-1:0] SIM_DNA   = '0
)(
   input  logic clk,
   input  logic read,
   input  logic shift,
   output logic dout
);

   logic                 din;
   logic [DNA_WIDTH-1:0] dna_sr;

   assign din  = 1'b0;
   assign dout = dna_sr[DNA_WIDTH-1];

   // Primitive model: parallel load of the ID on READ, MSB-first shift on SHIFT.
   always_ff @(posedge clk) begin
      if (read)
         dna_sr <= SIM_DNA;
      else if (shift)
         dna_sr <= DNA_WIDTH'({dna_sr, din});
   end

endmodule

// File: rtl/dna_reader.sv
// Device-DNA reader: waits, then runs NUM_PASSES load/settle/shift passes on
// the DNA_PORT, cross-checks the passes and publishes the ID, the pass
// disagreement flag and a masked match against the expected ID.
module dna_reader
   import dna_reader_pkg::*;
#(
   parameter int                   DNA_WIDTH   = DEF_DNA_WIDTH,
   parameter int                   READ_DELAY  = 20,
   parameter int                   SHIFT_DELAY = 24,
   parameter int                   NUM_PASSES  = 2,
   parameter bit                   AUTO_START  = 1'b1,
   parameter logic [DNA_WIDTH-1:0] SIM_DNA     = DNA_WIDTH'(DEF_SIM_DNA),
   parameter logic [DNA_WIDTH-1:0] EXP_DNA     = '0,
   parameter logic [DNA_WIDTH-1:0] EXP_MASK    = '1
)(
   input  logic                 sys_clk,
   input  logic                 sys_rst_n,
   input  logic                 start,
   output logic                 busy,
   output logic [DNA_WIDTH-1:0] dna_data,
   output logic                 dna_valid,
   output logic                 dna_done,
   output logic                 dna_err,
   output logic                 dna_match
);

   localparam int                   CW          = $clog2(max3(READ_DELAY, SHIFT_DELAY, DNA_WIDTH) + 1);
   localparam logic [CW-1:0]        WAIT_LAST   = CW'(READ_DELAY - 1);
   localparam logic [CW-1:0]        SETTLE_LAST = CW'(SHIFT_DELAY - 1);
   localparam logic [CW-1:0]        SHIFT_LAST  = CW'(DNA_WIDTH - 1);
   localparam logic [2:0]           PASS_LAST   = 3'(NUM_PASSES - 1);
   localparam logic [DNA_WIDTH-1:0] EXP_MASKED  = EXP_DNA & EXP_MASK;

   state_t               state;
   logic [CW-1:0]        cnt;
   logic [2:0]           pass_cnt;
   logic [DNA_WIDTH-1:0] shreg;
   logic [DNA_WIDTH-1:0] first;
   logic                 err_acc;
   logic                 auto_pend;
   logic                 prim_read;
   logic                 prim_shift;
   logic                 prim_dout;
   logic [DNA_WIDTH-1:0] final_id;
   logic                 final_err;

   // Result of the request as seen in CHECK, so a single-pass read can
   // publish the just-shifted word in the same edge that stores it.
   assign final_id  = (pass_cnt == 3'd0) ? shreg : first;
   assign final_err = err_acc | ((pass_cnt != 3'd0) && (shreg != first));

   dna_reader_port_if #(
      .DNA_WIDTH (DNA_WIDTH),
      .SIM_DNA   (SIM_DNA)
   ) u_port (
      .clk   (sys_clk),
      .read  (prim_read),
      .shift (prim_shift),
      .dout  (prim_dout)
   );

   // Sequencer with registered primitive controls and result outputs.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         pass_cnt   <= '0;
         shreg      <= '0;
         first      <= '0;
         err_acc    <= 1'b0;
         auto_pend  <= AUTO_START;
         prim_read  <= 1'b0;
         prim_shift <= 1'b0;
         busy       <= 1'b0;
         dna_data   <= '0;
         dna_valid  <= 1'b0;
         dna_done   <= 1'b0;
         dna_err    <= 1'b0;
         dna_match  <= 1'b0;
      end else begin
         dna_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start || auto_pend) begin
                  state     <= ST_WAIT;
                  auto_pend <= 1'b0;
                  busy      <= 1'b1;
                  cnt       <= '0;
                  pass_cnt  <= '0;
                  err_acc   <= 1'b0;
               end
            end
            ST_WAIT: begin
               if (cnt == WAIT_LAST) begin
                  cnt       <= '0;
                  prim_read <= 1'b1;
                  state     <= ST_LOAD;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_LOAD: begin
               prim_read <= 1'b0;
               state     <= ST_SETTLE;
            end
            ST_SETTLE: begin
               if (cnt == SETTLE_LAST) begin
                  cnt        <= '0;
                  prim_shift <= 1'b1;
                  state      <= ST_SHIFT;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_SHIFT: begin
               shreg <= DNA_WIDTH'({shreg, prim_dout});
               if (cnt == SHIFT_LAST) begin
                  cnt        <= '0;
                  prim_shift <= 1'b0;
                  state      <= ST_CHECK;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_CHECK: begin
               if (pass_cnt == 3'd0)
                  first <= shreg;
               else if (shreg != first)
                  err_acc <= 1'b1;
               if (pass_cnt == PASS_LAST) begin
                  state     <= ST_DONE;
                  dna_data  <= final_id;
                  dna_err   <= final_err;
                  dna_match <= ((final_id & EXP_MASK) == EXP_MASKED);
                  dna_valid <= 1'b1;
                  dna_done  <= 1'b1;
               end else begin
                  pass_cnt  <= pass_cnt + 1'b1;
                  prim_read <= 1'b1;
                  state     <= ST_LOAD;
               end
            end
            ST_DONE: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dna_reader.sv
// Directed bench for dna_reader: auto-run latency and result, match masking,
// pass disagreement, manual start, re-read hold and mid-shift reset.
module tb_dna_reader;

   localparam logic [56:0] SIM    = 57'h1_2345_6789_ABCD_EF;
   localparam logic [56:0] SIM_X1 = SIM ^ 57'd1;
   localparam logic [56:0] MASK0  = ~57'd1;

   logic clk = 1'b0;
   logic rst_n;
   logic start_def, start_man;

   logic        busy_def, valid_def, done_def, err_def, match_def;
   logic [56:0] data_def;
   logic        busy_err, valid_err, done_err, err_err, match_err;
   logic [56:0] data_err;
   logic        busy_nm, valid_nm, done_nm, err_nm, match_nm;
   logic [56:0] data_nm;
   logic        busy_mk, valid_mk, done_mk, err_mk, match_mk;
   logic [56:0] data_mk;
   logic        busy_man, valid_man, done_man, err_man, match_man;
   logic [56:0] data_man;

   int n_chk  = 0;
   int n_pass = 0;
   bit mutex_bad = 1'b0;

   always #5 clk = ~clk;

   dna_reader #(.SIM_DNA(SIM), .EXP_DNA(SIM)) u_def (
      .sys_clk(clk), .sys_rst_n(rst_n), .start(start_def), .busy(busy_def),
      .dna_data(data_def), .dna_valid(valid_def), .dna_done(done_def),
      .dna_err(err_def), .dna_match(match_def));

   dna_reader #(.SIM_DNA(SIM), .EXP_DNA(SIM)) u_err (
      .sys_clk(clk), .sys_rst_n(rst_n), .start(1'b0), .busy(busy_err),
      .dna_data(data_err), .dna_valid(valid_err), .dna_done(done_err),
      .dna_err(err_err), .dna_match(match_err));

   dna_reader #(.SIM_DNA(SIM), .EXP_DNA(SIM_X1)) u_nm (
      .sys_clk(clk), .sys_rst_n(rst_n), .start(1'b0), .busy(busy_nm),
      .dna_data(data_nm), .dna_valid(valid_nm), .dna_done(done_nm),
      .dna_err(err_nm), .dna_match(match_nm));

   dna_reader #(.SIM_DNA(SIM), .EXP_DNA(SIM_X1), .EXP_MASK(MASK0)) u_mk (
      .sys_clk(clk), .sys_rst_n(rst_n), .start(1'b0), .busy(busy_mk),
      .dna_data(data_mk), .dna_valid(valid_mk), .dna_done(done_mk),
      .dna_err(err_mk), .dna_match(match_mk));

   dna_reader #(.SIM_DNA(SIM), .EXP_DNA(SIM), .AUTO_START(1'b0), .NUM_PASSES(1)) u_man (
      .sys_clk(clk), .sys_rst_n(rst_n), .start(start_man), .busy(busy_man),
      .dna_data(data_man), .dna_valid(valid_man), .dna_done(done_man),
      .dna_err(err_man), .dna_match(match_man));

   // READ and SHIFT must never be high together on any instance.
   always @(negedge clk) begin
      if ((u_def.prim_read && u_def.prim_shift) || (u_err.prim_read && u_err.prim_shift) ||
          (u_man.prim_read && u_man.prim_shift))
         mutex_bad = 1'b1;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   initial begin
      int d_def, d_err, d_nm, d_mk, d_man, n_done_man;
      bit man_busy_seen, hold_bad;

      rst_n = 1'b0; start_def = 1'b0; start_man = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_state", 64'(u_def.state), 64'd0);
      check("rst_busy", busy_def, 1'b0);
      check("rst_data", data_def, 57'd0);
      check("rst_valid", valid_def, 1'b0);
      check("rst_done", done_def, 1'b0);
      check("rst_err_match", {err_def, match_def}, 2'b00);
      check("rst_prim", {u_def.prim_read, u_def.prim_shift}, 2'b00);

      // Auto run: done expected on edge 187 after release; pass 2 bit 10 flipped on u_err.
      @(negedge clk);
      rst_n = 1'b1;
      d_def = 0; d_err = 0; d_nm = 0; d_mk = 0; man_busy_seen = 1'b0;
      for (int k = 1; k <= 300; k++) begin
         @(posedge clk);
         #1;
         if (busy_man) man_busy_seen = 1'b1;
         if (k == 1) check("busy_rise", busy_def, 1'b1);
         if (k == 175) force u_err.prim_dout = ~SIM[10];
         if (k == 176) release u_err.prim_dout;
         if (d_def != 0 && k == d_def + 1) begin
            check("done_one_cycle", done_def, 1'b0);
            check("busy_fall", busy_def, 1'b0);
         end
         if (done_def && d_def == 0) begin
            d_def = k;
            check("busy_at_done", busy_def, 1'b1);
         end
         if (done_err && d_err == 0) d_err = k;
         if (done_nm && d_nm == 0) d_nm = k;
         if (done_mk && d_mk == 0) d_mk = k;
      end
      check("auto_latency", 64'(d_def), 64'd187);
      check("auto_data", data_def, SIM);
      check("auto_valid_match_err", {valid_def, match_def, err_def}, 3'b110);
      check("nomatch_latency", 64'(d_nm), 64'd187);
      check("nomatch_match", {valid_nm, match_nm}, 2'b10);
      check("mask_match", {valid_mk, match_mk, d_mk == 187}, 3'b111);
      check("pass_err_latency", 64'(d_err), 64'd187);
      check("pass_err_flag", err_err, 1'b1);
      check("pass_err_data", data_err, SIM);

      // Manual instance: idle for 500 cycles without start.
      repeat (200) begin
         @(posedge clk);
         #1;
         if (busy_man) man_busy_seen = 1'b1;
      end
      check("man_idle_500", man_busy_seen, 1'b0);

      // Manual start; extra pulses while busy and on the DONE->IDLE edge.
      @(negedge clk);
      start_man = 1'b1;
      d_man = 0; n_done_man = 0;
      for (int k = 1; k <= 300; k++) begin
         @(posedge clk);
         #1;
         if (k == 1 || k == 21 || k == 61 || k == 105) start_man = 1'b0;
         if (k == 20 || k == 60 || k == 104) start_man = 1'b1;
         if (done_man) begin
            n_done_man++;
            if (d_man == 0) d_man = k;
         end
         if (k == 106) check("man_no_accept_on_exit", busy_man, 1'b0);
      end
      check("man_latency", 64'(d_man), 64'd104);
      check("man_single_done", 64'(n_done_man), 64'd1);
      check("man_result", {data_man, valid_man, match_man, err_man}, {SIM, 3'b110});

      // Re-read on the default instance: outputs hold until the new done.
      @(negedge clk);
      start_def = 1'b1;
      d_def = 0; hold_bad = 1'b0;
      for (int k = 1; k <= 300; k++) begin
         @(posedge clk);
         #1;
         if (k == 1) start_def = 1'b0;
         if (d_def == 0 && (data_def !== SIM || valid_def !== 1'b1 || busy_def !== 1'b1))
            hold_bad = 1'b1;
         if (done_def && d_def == 0) d_def = k;
      end
      check("reread_hold", hold_bad, 1'b0);
      check("reread_latency", 64'(d_def), 64'd187);
      check("reread_result", {valid_def, match_def, err_def}, 3'b110);

      // Reset in the middle of the first shift, then a clean auto run.
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (100) @(posedge clk);
      #1;
      check("mid_in_shift", u_def.prim_shift, 1'b1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_outs", {busy_def, valid_def, done_def, err_def, match_def}, 5'b00000);
      check("mid_rst_data", data_def, 57'd0);
      check("mid_rst_prim", {u_def.prim_read, u_def.prim_shift}, 2'b00);
      @(negedge clk);
      rst_n = 1'b1;
      d_def = 0;
      for (int k = 1; k <= 250; k++) begin
         @(posedge clk);
         #1;
         if (done_def && d_def == 0) d_def = k;
      end
      check("post_rst_latency", 64'(d_def), 64'd187);
      check("post_rst_result", {data_def, valid_def, match_def, err_def}, {SIM, 3'b110});

      check("read_shift_exclusive", mutex_bad, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
